// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
// Purpose : groups the control, byte-stream and instruction-memory write
//           signals of the program loader into one bundle.
// Signals :
//   start          host -> loader  one-cycle load request
//   program_len    host -> loader  program length in words
//   byte_valid     host -> loader  byte_data is valid
//   byte_data      host -> loader  stream byte
//   byte_ready     loader -> host  loader accepts a byte this cycle
//   mem_write_en   loader -> mem   one-cycle instruction-memory write strobe
//   PC_write       loader -> mem   byte address of the current write
//   instruction_in loader -> mem   assembled 32-bit instruction word
//   core_hold      loader -> core  keep the core in reset
//   busy/done/error loader -> host load status
// Modports: master = host/stream side, slave = loader side.
// -----------------------------------------------------------------------------
interface instr_loader_if #(
  parameter int PC_SIZE = 10
);
  logic                 start;
  logic [PC_SIZE-2:0]   program_len;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_write_en;
  logic [PC_SIZE-1:0]   PC_write;
  logic [31:0]          instruction_in;
  logic                 core_hold;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    output start, program_len, byte_valid, byte_data,
    input  byte_ready, mem_write_en, PC_write, instruction_in,
           core_hold, busy, done, error
  );

  modport slave (
    input  start, program_len, byte_valid, byte_data,
    output byte_ready, mem_write_en, PC_write, instruction_in,
           core_hold, busy, done, error
  );
endinterface

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Purpose : program loader in front of the core's instruction-fetch stage.
//           Packs a byte stream into 32-bit little-endian words, writes each
//           word to consecutive instruction-memory addresses, holds the core
//           in reset while loading and verifies a trailing 8-bit checksum
//           (sum of all program bytes modulo 256).
// Ports   :
//   clock   single clock, all state on the rising edge
//   reset   asynchronous, active-low
//   io_bus  instr_loader_if.slave (stream, memory write port, status)
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int PC_SIZE   = 10,
  parameter int MAX_WORDS = 2**(PC_SIZE-2)
) (
  input  logic           clock,
  input  logic           reset,
  instr_loader_if.slave  io_bus
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    CHECK,
    DONE
  } state_t;

  // Widened so that program_len values above MAX_WORDS compare correctly.
  localparam logic [PC_SIZE-1:0] MAX_WORDS_L = PC_SIZE'(MAX_WORDS);

  state_t               r_state;
  state_t               w_nextState;

  logic [PC_SIZE-2:0]   r_len;
  logic [PC_SIZE-2:0]   r_wordCnt;
  logic [1:0]           r_byteCnt;
  logic [7:0]           r_sum;
  logic [23:0]          r_word;
  logic                 r_error;
  logic [PC_SIZE-1:0]   r_pcWrite;
  logic [31:0]          r_instr;

  logic                 w_byteReady;
  logic                 w_memWriteEn;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_startOk;
  logic                 w_tooLong;
  logic                 w_lastByte;
  logic [PC_SIZE-2:0]   w_wordCntNext;
  logic [PC_SIZE-1:0]   w_pcAddr;

  assign w_accept      = io_bus.byte_valid && w_byteReady;
  assign w_startOk     = io_bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_tooLong     = {1'b0, io_bus.program_len} > MAX_WORDS_L;
  assign w_lastByte    = (r_byteCnt == 2'd3);
  assign w_wordCntNext = r_wordCnt + 1'b1;
  // word_cnt*4 truncated to the address width; the length check keeps it
  // from ever wrapping.
  assign w_pcAddr      = PC_SIZE'({r_wordCnt, 2'b00});

  // State register. Reset lands in IDLE immediately, which also drops the
  // decoded write strobe without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (io_bus.start) begin
          if (w_tooLong) begin
            w_nextState = DONE;
          end else if (io_bus.program_len == '0) begin
            w_nextState = CHECK;
          end else begin
            w_nextState = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (w_accept && w_lastByte) begin
          w_nextState = WRITE;
        end
      end
      WRITE: begin
        if (w_wordCntNext == r_len) begin
          w_nextState = CHECK;
        end else begin
          w_nextState = COLLECT;
        end
      end
      CHECK: begin
        if (w_accept) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_byteReady  = 1'b0;
    w_memWriteEn = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      COLLECT: begin
        w_byteReady = 1'b1;
        w_busy      = 1'b1;
      end
      WRITE: begin
        w_memWriteEn = 1'b1;
        w_busy       = 1'b1;
      end
      CHECK: begin
        w_byteReady = 1'b1;
        w_busy      = 1'b1;
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath: counters, byte lanes, running sum and the write-port
  // registers. PC_write/instruction_in are loaded together with the 4th
  // byte so they are valid throughout WRITE and hold afterwards, while the
  // lane register is already free to collect the next word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_wordCnt <= '0;
      r_byteCnt <= '0;
      r_sum     <= '0;
      r_word    <= '0;
      r_error   <= 1'b0;
      r_pcWrite <= '0;
      r_instr   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_startOk) begin
            r_len     <= io_bus.program_len;
            r_wordCnt <= '0;
            r_byteCnt <= '0;
            r_sum     <= '0;
            r_error   <= w_tooLong;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_byteCnt <= r_byteCnt + 1'b1;
            r_sum     <= r_sum + io_bus.byte_data;
            case (r_byteCnt)
              2'd0: r_word[7:0]   <= io_bus.byte_data;
              2'd1: r_word[15:8]  <= io_bus.byte_data;
              2'd2: r_word[23:16] <= io_bus.byte_data;
              default: begin
                r_pcWrite <= w_pcAddr;
                r_instr   <= {io_bus.byte_data, r_word};
              end
            endcase
          end
        end
        WRITE: begin
          r_wordCnt <= w_wordCntNext;
          r_byteCnt <= '0;
        end
        CHECK: begin
          if (w_accept) begin
            r_error <= (io_bus.byte_data != r_sum);
          end
        end
        default: begin
          r_byteCnt <= '0;
        end
      endcase
    end
  end

  assign io_bus.byte_ready     = w_byteReady;
  assign io_bus.mem_write_en   = w_memWriteEn;
  assign io_bus.PC_write       = r_pcWrite;
  assign io_bus.instruction_in = r_instr;
  assign io_bus.busy           = w_busy;
  assign io_bus.done           = w_done;
  assign io_bus.error          = r_error;
  // A failed load keeps the core parked until the next start.
  assign io_bus.core_hold      = w_busy || (w_done && r_error);

endmodule
